or8_operand_loader: RTL
=======================

Name: or8_operand_loader

Overview:
- Upstream sequencer for the 8-bit bitwise-OR array.
- Accepts a byte stream over a valid/ready handshake and assembles operand pairs: first byte is a, second byte is b.
- Holds op_a/op_b stable while the OR array settles, then captures its result and offers it on a valid/ready result port.
- Counts completed operations.

Parameters:
- WIDTH, 8, operand/result width; must match the OR array width.
- EVAL_CYCLES, 1, cycles op_a/op_b are held before or_result is sampled; legal range 1..15.
- CNT_W, 16, width of the op_count completed-operation counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort of the current operation, active-high
- in_data  in  WIDTH  operand byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept in_data
- op_a  out  WIDTH  operand a to OR array (registered)
- op_b  out  WIDTH  operand b to OR array (registered)
- or_result  in  WIDTH  combinational result from OR array
- res_data  out  WIDTH  captured result (registered)
- res_valid  out  1  res_data valid
- res_ready  in  1  consumer accepts res_data
- busy  out  1  high in any state other than S_A
- op_count  out  CNT_W  number of completed result handshakes, wraps

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=S_A, op_a=0, op_b=0, res_data=0, res_valid=0, op_count=0, eval counter=0.
  - in_ready forced 0 while rst_n is low.
- in_ready is combinational: 1 in S_A and S_B, 0 otherwise. busy is combinational from state. res_valid is registered; it is 1 exactly in S_OUT.
- S_A: on in_valid&in_ready, op_a<=in_data, go to S_B. Otherwise stay.
- S_B: on in_valid&in_ready, op_b<=in_data, eval counter<=EVAL_CYCLES-1, go to S_EVAL. Otherwise stay. op_a is held.
- S_EVAL: in_ready=0 and input is ignored.
  - Counter nonzero: decrement.
  - Counter zero: res_data<=or_result, res_valid<=1, go to S_OUT.
- S_OUT: res_data and res_valid are held stable until res_ready.
  - On res_valid&res_ready: res_valid<=0, op_count<=op_count+1 (mod 2^CNT_W), go to S_A.
- Latency: if the b handshake occurs in cycle n:
  - S_EVAL occupies cycles n+1 .. n+EVAL_CYCLES.
  - or_result is sampled at the end of cycle n+EVAL_CYCLES.
  - res_valid is high from cycle n+EVAL_CYCLES+1.
  - With EVAL_CYCLES=1 and res_ready held high, one operation takes 4 cycles: A, B, EVAL, OUT. There is no overlap between operations.
- op_a/op_b are never cleared except by reset. They keep their last values until overwritten in S_A/S_B.
- in_valid low in S_A/S_B: wait indefinitely, no timeout.
- clr, in any state:
  - Next state is S_A and res_valid<=0.
  - Any in-flight handshake in that cycle is ignored: no operand capture, no op_count increment even if res_ready=1.
  - op_a, op_b, res_data and op_count keep their values.
  - clr has priority over all other transitions.
- in_ready is 0 during clr cycles only via the state change; in the clr cycle itself in_ready still reflects the current state. Because the handshake in that cycle is ignored, upstream must treat a byte presented in a clr cycle as dropped.
- Reset mid-operation returns to reset values immediately. Partial operands are discarded.
- op_count wraps from 2^CNT_W-1 to 0 without a flag.

Test Plan:
- Basic OR: in_data 0x0F then 0xF0, res_ready=1 → op_a=0x0F, op_b=0xF0, res_data=0xFF and res_valid high exactly 2 cycles after the b handshake; op_count=1.
- Backpressure: bytes 0xA5 then 0x00, res_ready low for 5 cycles → res_data=0xA5 and res_valid=1 stable all 5 cycles, in_ready=0 throughout; op_count increments only on the res_ready cycle.
- Input gaps plus EVAL_CYCLES=3: in_valid toggling 1,0,0,1 with bytes 0x01, 0x80 → only 2 captures; res_data=0x81; res_valid high 4 cycles after the b handshake.
- Abort: send 0x3C, assert clr in S_B with in_valid=1 and in_data=0xC3 → state returns to S_A, op_b unchanged, no result. The next pair 0x11, 0x22 gives res_data=0x33.
- Reset mid-S_EVAL: rst_n low for one cycle during S_EVAL → all outputs 0 asynchronously, res_valid never asserts; the next pair 0xFF, 0x00 gives 0xFF and op_count=1.
- Counter wrap with CNT_W=4: 16 back-to-back operations with random operands → op_count goes 15 then 0, and every res_data equals a|b.

Source files
------------

// File: rtl/or8_operand_loader.sv
// Operand sequencer for the bitwise-OR array: gathers an a/b byte pair, holds it while the
// array settles, captures the result and offers it on a valid/ready port.
module or8_operand_loader #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned EVAL_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] or_result,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned EvalW = 4;
  localparam logic [EvalW-1:0] EvalLoad = EvalW'(EVAL_CYCLES - 1);

  typedef enum logic [1:0] {StA, StB, StEval, StOut} state_e;

  state_e           state_q, state_d;
  logic [EvalW-1:0] eval_cnt_q, eval_cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             in_fire, res_fire;

  assign in_fire  = in_valid & in_ready;
  assign res_fire = res_valid_q & res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StA;
      eval_cnt_q  <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      eval_cnt_q  <= eval_cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StA:     if (in_fire) state_d = StB;
      StB:     if (in_fire) state_d = StEval;
      StEval:  if (eval_cnt_q == '0) state_d = StOut;
      StOut:   if (res_fire) state_d = StA;
      default: state_d = StA;
    endcase
    // Abort wins over every handshake in the same cycle.
    if (clr) state_d = StA;
  end

  always_comb begin
    eval_cnt_d  = eval_cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_data_d  = res_data_q;
    op_count_d  = op_count_q;
    res_valid_d = (state_d == StOut);
    if (!clr) begin
      if (state_q == StA && in_fire) op_a_d = in_data;
      if (state_q == StB && in_fire) begin
        op_b_d     = in_data;
        eval_cnt_d = EvalLoad;
      end
      if (state_q == StEval) begin
        if (eval_cnt_q != '0) eval_cnt_d = eval_cnt_q - EvalW'(1);
        else                  res_data_d = or_result;
      end
      if (res_fire) op_count_d = op_count_q + CNT_W'(1);
    end
  end

  always_comb begin
    in_ready  = rst_n && (state_q == StA || state_q == StB);
    busy      = (state_q != StA);
    op_a      = op_a_q;
    op_b      = op_b_q;
    res_data  = res_data_q;
    res_valid = res_valid_q;
    op_count  = op_count_q;
  end

endmodule
